// File: rtl/charge_session_controller.sv
// Session sequencer for the coin-operated charger: amount entry, timed charge, done hold.
// Optional low-time warning output is built only when LOW_TIME_WARN_EN is defined.
module charge_session_controller #(
   parameter int unsigned CLK_HZ        = 50000000,
   parameter int unsigned MAX_AMOUNT    = 20,
   parameter int unsigned SEC_PER_UNIT  = 2,
   parameter int unsigned ENTRY_TIMEOUT = 10,
   parameter int unsigned DONE_HOLD     = 3,
   parameter int unsigned WARN_SECS     = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_value,
   input  logic       start,
   input  logic       cancel,
   output logic [4:0] amount,
   output logic [5:0] remaining_time,
   output logic       charging,
   output logic       done,
   output logic [2:0] state,
   output logic       warn
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ENTRY1 = 3'd1;
   localparam logic [2:0] S_ENTRY2 = 3'd2;
   localparam logic [2:0] S_CHARGE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam int unsigned PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned SMAX = (ENTRY_TIMEOUT > DONE_HOLD) ? ENTRY_TIMEOUT : DONE_HOLD;
   localparam int unsigned SW   = $clog2(SMAX + 1);

   logic [PW-1:0] pre_cnt;
   logic [SW-1:0] sec_cnt;
   logic          tick;
   logic          key_ok;
   logic          key_nz;
   logic          entry_timeout;
   logic          done_expire;
   logic [7:0]    entry_sum;
   logic [4:0]    entry_amount;
   logic [4:0]    digit_amount;
   logic [5:0]    charge_load;

   logic [2:0]    state_nxt;
   logic [4:0]    amount_nxt;
   logic [5:0]    rt_nxt;

   assign tick          = (pre_cnt == PW'(CLK_HZ - 1));
   assign key_ok        = key_valid && (key_value <= 4'd9);
   assign key_nz        = key_ok && (key_value != 4'd0);
   assign entry_timeout = tick && (sec_cnt == SW'(ENTRY_TIMEOUT - 1));
   assign done_expire   = tick && (sec_cnt == SW'(DONE_HOLD - 1));

   // Second digit is accumulated at 8 bits so 10*9+9 cannot wrap before the clamp.
   assign entry_sum    = ({3'b000, amount} * 8'd10) + {4'b0000, key_value};
   assign entry_amount = (entry_sum > 8'(MAX_AMOUNT)) ? 5'(MAX_AMOUNT) : entry_sum[4:0];
   assign digit_amount = ({1'b0, key_value} > 5'(MAX_AMOUNT)) ? 5'(MAX_AMOUNT)
                                                               : {1'b0, key_value};
   assign charge_load  = 6'(SEC_PER_UNIT * amount);

   always_comb begin
      state_nxt  = state;
      amount_nxt = amount;
      rt_nxt     = remaining_time;
      case (state)
         S_IDLE: begin
            amount_nxt = '0;
            rt_nxt     = '0;
            if (key_nz) begin
               state_nxt  = S_ENTRY1;
               amount_nxt = digit_amount;
            end
         end
         S_ENTRY1, S_ENTRY2: begin
            if (cancel) begin
               state_nxt  = S_IDLE;
               amount_nxt = '0;
               rt_nxt     = '0;
            end else if (start) begin
               state_nxt = S_CHARGE;
               rt_nxt    = charge_load;
            end else if (key_ok && (state == S_ENTRY1)) begin
               state_nxt  = S_ENTRY2;
               amount_nxt = entry_amount;
            end else if (entry_timeout) begin
               state_nxt  = S_IDLE;
               amount_nxt = '0;
               rt_nxt     = '0;
            end
         end
         S_CHARGE: begin
            if (cancel) begin
               state_nxt  = S_IDLE;
               amount_nxt = '0;
               rt_nxt     = '0;
            end else if (tick) begin
               rt_nxt = remaining_time - 6'd1;
               if (remaining_time == 6'd1)
                  state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (key_nz) begin
               state_nxt  = S_ENTRY1;
               amount_nxt = digit_amount;
               rt_nxt     = '0;
            end else if (done_expire) begin
               state_nxt  = S_IDLE;
               amount_nxt = '0;
               rt_nxt     = '0;
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            amount_nxt = '0;
            rt_nxt     = '0;
         end
      endcase
   end

   // Both time bases restart on any state change so each state's first second is full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         sec_cnt <= '0;
      end else if (state_nxt != state) begin
         pre_cnt <= '0;
         sec_cnt <= '0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
         if (tick && (sec_cnt != SW'(SMAX)))
            sec_cnt <= sec_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         amount         <= '0;
         remaining_time <= '0;
         charging       <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_nxt;
         amount         <= amount_nxt;
         remaining_time <= rt_nxt;
         charging       <= (state_nxt == S_CHARGE);
         done           <= (state_nxt == S_DONE);
      end
   end

`ifdef LOW_TIME_WARN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         warn <= 1'b0;
      else
         warn <= (state_nxt == S_CHARGE) && (rt_nxt != '0) && (rt_nxt <= 6'(WARN_SECS));
   end
`else
   assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_charge_session_controller.sv
// Directed bench for charge_session_controller at CLK_HZ=4; expectations are hand-computed.
module tb_charge_session_controller;

   logic       clk;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key_value;
   logic       start;
   logic       cancel;
   logic [4:0] amount;
   logic [5:0] remaining_time;
   logic       charging;
   logic       done;
   logic [2:0] state;
   logic       warn;

   int checks = 0;
   int errors = 0;

   charge_session_controller #(.CLK_HZ(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_valid(key_valid),
      .key_value(key_value),
      .start(start),
      .cancel(cancel),
      .amount(amount),
      .remaining_time(remaining_time),
      .charging(charging),
      .done(done),
      .state(state),
      .warn(warn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // All pulse tasks start and end on a negedge; outputs are valid on return.
   task automatic press(input logic [3:0] d);
      key_valid = 1'b1;
      key_value = d;
      @(negedge clk);
      key_valid = 1'b0;
      key_value = 4'd0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_cancel();
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
   endtask

   task automatic wait_rt(input logic [5:0] v, input string tag);
      int n = 0;
      while (remaining_time !== v && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(tag, remaining_time, v);
   endtask

   initial begin
      int cnt;
      int warn_bad;
      logic exp_warn;

      rst_n = 1'b0;
      key_valid = 1'b0;
      key_value = 4'd0;
      start = 1'b0;
      cancel = 1'b0;
      @(negedge clk);
      check("rst_state", state, 0);
      check("rst_amount", amount, 0);
      check("rst_rt", remaining_time, 0);
      check("rst_flags", {charging, done, warn}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Full session: 15 units -> 30 s -> 120 cycles charging, 12 cycles done.
      press(4'd1);
      check("s1_state_e1", state, 1);
      check("s1_amt1", amount, 1);
      press(4'd5);
      check("s1_state_e2", state, 2);
      check("s1_amt15", amount, 15);
      pulse_start();
      check("s1_rt30", remaining_time, 30);
      check("s1_state_chg", state, 3);
      cnt = 0;
      while (charging === 1'b1 && cnt < 300) begin
         cnt++;
         @(negedge clk);
      end
      check("s1_charge_cycles", cnt, 120);
      check("s1_rt_at_done", remaining_time, 0);
      cnt = 0;
      while (done === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("s1_done_cycles", cnt, 12);
      check("s1_idle", state, 0);
      check("s1_amt_idle", amount, 0);

      // Clamp to MAX_AMOUNT, extra key ignored in ENTRY2.
      press(4'd3);
      press(4'd7);
      check("s2_clamp", amount, 20);
      press(4'd9);
      check("s2_third_key_amt", amount, 20);
      check("s2_third_key_state", state, 2);
      pulse_start();
      check("s2_rt40", remaining_time, 40);
      pulse_cancel();
      check("s2_cancel_state", state, 0);

      // Cancel mid-charge.
      press(4'd4);
      pulse_start();
      check("s3_rt8", remaining_time, 8);
      wait_rt(6'd5, "s3_reach5");
      pulse_cancel();
      check("s3_state", state, 0);
      check("s3_charging", charging, 0);
      check("s3_rt", remaining_time, 0);
      check("s3_amt", amount, 0);

      // Entry timeout boundary: still ENTRY1 at 39 cycles, IDLE at 40.
      press(4'd2);
      repeat (39) @(negedge clk);
      check("s4_before_timeout", state, 1);
      @(negedge clk);
      check("s4_timeout_state", state, 0);
      check("s4_timeout_amt", amount, 0);
      press(4'd0);
      check("s4_key0_idle", state, 0);
      pulse_start();
      check("s4_start_idle", state, 0);
      press(4'd2);
      cancel = 1'b1;
      start = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      start = 1'b0;
      check("s4_cancel_over_start", state, 0);
      check("s4_cancel_rt", remaining_time, 0);

      // Asynchronous reset mid-charge.
      press(4'd9);
      pulse_start();
      check("s5_rt18", remaining_time, 18);
      wait_rt(6'd17, "s5_reach17");
      #2;
      rst_n = 1'b0;
      #1;
      check("s5_async_state", state, 0);
      check("s5_async_rt", remaining_time, 0);
      check("s5_async_amt", amount, 0);
      check("s5_async_flags", {charging, done, warn}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      press(4'd6);
      check("s5_resume_state", state, 1);
      check("s5_resume_amt", amount, 6);
      pulse_cancel();

      // Low-time warning tracks remaining_time in 1..5 while charging.
      press(4'd3);
      pulse_start();
      check("s6_rt6", remaining_time, 6);
      warn_bad = 0;
      cnt = 0;
      while (charging === 1'b1 && cnt < 100) begin
`ifdef LOW_TIME_WARN_EN
         exp_warn = (remaining_time >= 6'd1) && (remaining_time <= 6'd5);
`else
         exp_warn = 1'b0;
`endif
         if (warn !== exp_warn) warn_bad++;
         cnt++;
         @(negedge clk);
      end
      check("s6_charge_cycles", cnt, 24);
      check("s6_warn_track", warn_bad, 0);
      check("s6_done_state", state, 4);
      check("s6_warn_done", warn, 0);

      // New key in DONE starts a fresh session.
      press(4'd8);
      check("s7_done_key_state", state, 1);
      check("s7_done_key_amt", amount, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/charge_session_controller.md
# charge_session_controller

Session sequencer for the coin-operated charger. It collects the keyed amount, arms and times the charge, drives the charging relay and returns to idle on completion, cancel or entry timeout. It sits between the keypad decoder (one-cycle key pulses) and the display/relay drivers. All time bases are derived internally from `clk`.

## Interface
Parameters:
- `CLK_HZ`, default 50000000: clk cycles per second; the internal prescaler wraps here.
- `MAX_AMOUNT`, default 20: clamp value for the entered amount.
- `SEC_PER_UNIT`, default 2: charge seconds per money unit.
- `ENTRY_TIMEOUT`, default 10: seconds without a key in ENTRY1/ENTRY2 before abandoning the session.
- `DONE_HOLD`, default 3: seconds spent in DONE.
- `WARN_SECS`, default 5: low-time threshold. Used only with `LOW_TIME_WARN_EN`.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_valid` input 1: one-cycle pulse; `key_value` is valid in that cycle.
- `key_value` input 4: digit 0-9; values above 9 are ignored.
- `start` input 1: one-cycle start request.
- `cancel` input 1: one-cycle abort request.
- `amount` output 5: entered money, binary, 0..MAX_AMOUNT.
- `remaining_time` output 6: charge seconds left, binary.
- `charging` output 1: relay enable; high only in CHARGE.
- `done` output 1: high only in DONE.
- `state` output 3: IDLE=0, ENTRY1=1, ENTRY2=2, CHARGE=3, DONE=4.
- `warn` output 1: low-time warning. See Configuration.

## Operation
- All outputs are registered. Reset values: `state` = IDLE, and every other output is 0.
- Prescaler: counts 0..CLK_HZ-1 and emits an internal `tick` at CLK_HZ-1. It clears to 0 on every state change, so each state's first second is full length. A second counter counts ticks for the timeout and hold periods and also clears on every state change.
- IDLE: `amount` = 0 and `remaining_time` = 0. A key with digit 1-9 loads `amount` with that digit and moves to ENTRY1. Digit 0, `start` and `cancel` are ignored.
- ENTRY1:
  - A key with digit d sets `amount` = min(10*amount + d, MAX_AMOUNT) and moves to ENTRY2. The product is computed at 8 bits before the clamp.
  - `start` loads `remaining_time` = SEC_PER_UNIT*amount and moves to CHARGE.
  - `cancel`, or ENTRY_TIMEOUT ticks with no key, returns to IDLE.
- ENTRY2: further keys are ignored and do not restart the timeout. `start`, `cancel` and timeout behave as in ENTRY1.
- CHARGE:
  - Each tick decrements `remaining_time`. The tick that takes it from 1 to 0 moves the block to DONE.
  - `cancel` returns to IDLE and clears `amount` and `remaining_time`.
  - Keys and `start` are ignored.
- DONE:
  - After DONE_HOLD ticks, returns to IDLE.
  - A key with digit 1-9 starts a new session immediately: `amount` = digit, next state ENTRY1.
- Priority when several events share a cycle: `cancel` > `start` > key > tick/timeout. In CHARGE, `cancel` together with the final tick goes to IDLE, not DONE.
- Since ENTRY1 implies `amount` ≥ 1, a zero-length charge cannot occur.

## Timing
- An event pulse at cycle n produces its state and output update visible at cycle n+1.
- `start` at cycle n:
  - `charging` = 1 and `remaining_time` loaded at n+1.
  - First decrement CLK_HZ cycles after entry.
  - Total CHARGE duration is exactly SEC_PER_UNIT*amount*CLK_HZ cycles.
- `done` rises in the cycle after the final tick and lasts DONE_HOLD*CLK_HZ cycles.
- Entry timeout fires ENTRY_TIMEOUT*CLK_HZ cycles after the last accepted key.
- `rst_n` asserted at any time (mid-charge included) forces reset values immediately, with no clock required. Operation resumes at the first clk edge after deassertion.
- Inputs are assumed synchronous to `clk`. Pulses longer than one cycle are treated as repeated events.

## Configuration
- `LOW_TIME_WARN_EN` defined: `warn` is registered high while `state` = CHARGE and 0 < `remaining_time` ≤ WARN_SECS. It updates in the same cycle as `remaining_time` and clears on leaving CHARGE.
- `LOW_TIME_WARN_EN` undefined: `warn` is tied to constant 0 and no comparator is built.

## Test plan
All scenarios use `CLK_HZ`=4.
- Keys 1,5 then `start` -> `amount`=15 and `remaining_time`=30. `charging` stays high for 120 cycles, then `done` is high for 12 cycles, then `state`=0.
- Keys 3,7, `start` -> `amount`=20 (clamped) and `remaining_time`=40. A third key in ENTRY2 leaves `amount` at 20.
- Key 4, `start` -> `remaining_time`=8. `cancel` when `remaining_time`=5 -> next cycle `state`=0, `charging`=0, `remaining_time`=0 and `amount`=0.
- Key 2, then idle for 40 cycles -> IDLE with `amount`=0. Key 0 or `start` in IDLE leaves `state`=0. `cancel` and `start` in the same cycle in ENTRY1 -> IDLE.
- `rst_n` low during CHARGE with `remaining_time`=17 -> all outputs 0 without a clock edge. After release, key 6 -> ENTRY1 with `amount`=6.
- With `LOW_TIME_WARN_EN` defined, key 3, `start` -> `warn` rises when `remaining_time` reaches 5 and falls on entering DONE. Without the macro, `warn` stays 0 throughout.
